// File: rtl/z80_dbg_pkg.sv
// Shared types for the Z80 trace debugger: REG bus field offsets,
// debug state encoding and the register snapshot bundle.
package z80_dbg_pkg;

  localparam int REG_W   = 212;
  localparam int ACC_LSB = 0;
  localparam int F_LSB   = 8;
  localparam int SP_LSB  = 48;
  localparam int PC_LSB  = 64;
  localparam int BC_LSB  = 80;
  localparam int DE_LSB  = 96;
  localparam int HL_LSB  = 112;
  localparam int IX_LSB  = 128;
  localparam int IY_LSB  = 192;

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    STEP
  } dbg_state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] sp;
    logic [15:0] af;
    logic [15:0] bc;
    logic [15:0] de;
    logic [15:0] hl;
    logic [15:0] ix;
    logic [15:0] iy;
  } z80_snap_t;

endpackage

// File: rtl/z80_trace_fifo.sv
// Circular PC history FIFO: a push when full drops the oldest entry,
// read data is registered and holds when a pop finds the FIFO empty.
module z80_trace_fifo
  import z80_dbg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             empty, full, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

  // Overwrite on full advances the read side too, keeping the newest DEPTH
  always_comb begin
    do_pop = pop_i & ~empty;
    wp_d   = push_i ? wp_q + AW'(1) : wp_q;
    rp_d   = (do_pop | (push_i & full)) ? rp_q + AW'(1) : rp_q;
    rd_d   = do_pop ? mem_q[rp_q] : rd_q;
    cnt_d  = cnt_q;
    if (push_i & ~full & ~do_pop)
      cnt_d = cnt_q + CNT_W'(1);
    else if (do_pop & ~push_i)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      rd_q  <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i)
      mem_q[wp_q] <= wdata_i;
  end

  assign rdata_o = rd_q;
  assign count_o = cnt_q;
  assign empty_o = empty;
  assign full_o  = full;

endmodule

// File: rtl/z80_trace_debugger.sv
// Z80 M1 snapshot, PC breakpoint, run/step control and PC trace.
// Optional SP window guard enabled by Z80_DBG_SP_GUARD_EN.
module z80_trace_debugger
  import z80_dbg_pkg::*;
#(
  parameter int NUM_BP      = 4,
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_W       = $clog2(TRACE_DEPTH) + 1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  m1_n,
  input  logic [REG_W-1:0]      REG_in,
  input  logic [16*NUM_BP-1:0]  bp_addr,
  input  logic [NUM_BP-1:0]     bp_en,
  input  logic                  halt_req,
  input  logic                  run,
  input  logic                  step,
`ifdef Z80_DBG_SP_GUARD_EN
  input  logic [15:0]           sp_lo,
  input  logic [15:0]           sp_hi,
  output logic                  sp_fault,
`endif
  output logic                  cpu_wait,
  output logic                  halted,
  output logic                  bp_hit,
  output logic [2:0]            bp_idx,
  output logic [15:0]           PC,
  output logic [15:0]           SP,
  output logic [15:0]           AF,
  output logic [15:0]           BC,
  output logic [15:0]           DE,
  output logic [15:0]           HL,
  output logic [15:0]           IX,
  output logic [15:0]           IY,
  input  logic                  tr_rd,
  output logic [15:0]           tr_data,
  output logic [CNT_W-1:0]      tr_count,
  output logic                  tr_empty,
  output logic                  tr_full
);

  dbg_state_t state_q, state_d;
  z80_snap_t  snap_q, snap_d;
  logic       m1_prev_q;
  logic       cap, hit, spf;
  logic [2:0] hit_idx;
  logic       halt_cap, leave;
  logic       bp_hit_q, bp_hit_d;
  logic [2:0] bp_idx_q, bp_idx_d;
  logic       unused_reg;

  // One strobe per M1 falling edge, however long M1 is stretched
  assign cap = ce & ~m1_n & m1_prev_q;

  always_comb begin
    snap_d    = '0;
    snap_d.pc = REG_in[PC_LSB +: 16];
    snap_d.sp = REG_in[SP_LSB +: 16];
    snap_d.af = {REG_in[F_LSB +: 8], REG_in[ACC_LSB +: 8]};
    snap_d.bc = REG_in[BC_LSB +: 16];
    snap_d.de = REG_in[DE_LSB +: 16];
    snap_d.hl = REG_in[HL_LSB +: 16];
    snap_d.ix = REG_in[IX_LSB +: 16];
    snap_d.iy = REG_in[IY_LSB +: 16];
  end

  assign unused_reg = ^{REG_in[47:16], REG_in[191:144], REG_in[211:208]};

  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (bp_addr[16*i +: 16] == snap_d.pc)) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

`ifdef Z80_DBG_SP_GUARD_EN
  assign spf = (snap_d.sp < sp_lo) | (snap_d.sp > sp_hi);
`else
  assign spf = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (cap & (hit | halt_req | spf)) state_d = HALTED;
      HALTED:  if (run) state_d = RUN;
               else if (step) state_d = STEP;
      STEP:    if (cap) state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    cpu_wait = (state_q == HALTED);
    halted   = (state_q == HALTED);
  end

  assign halt_cap = (state_q != HALTED) & (state_d == HALTED);
  assign leave    = (state_q == HALTED) & (state_d != HALTED);
  assign bp_hit_d = halt_cap ? hit : bp_hit_q;
  assign bp_idx_d = (halt_cap & hit) ? hit_idx : bp_idx_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      m1_prev_q <= 1'b1;
      snap_q    <= '0;
      bp_hit_q  <= 1'b0;
      bp_idx_q  <= 3'd0;
    end else begin
      if (ce)
        m1_prev_q <= m1_n;
      if (cap)
        snap_q <= snap_d;
      bp_hit_q <= bp_hit_d;
      bp_idx_q <= bp_idx_d;
    end
  end

`ifdef Z80_DBG_SP_GUARD_EN
  logic sp_fault_q, sp_fault_d;

  assign sp_fault_d = halt_cap ? spf : (leave ? 1'b0 : sp_fault_q);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      sp_fault_q <= 1'b0;
    else
      sp_fault_q <= sp_fault_d;
  end

  assign sp_fault = sp_fault_q;
`endif

  z80_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (16),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .push_i  (cap),
    .wdata_i (snap_d.pc),
    .pop_i   (tr_rd),
    .rdata_o (tr_data),
    .count_o (tr_count),
    .empty_o (tr_empty),
    .full_o  (tr_full)
  );

  assign bp_hit = bp_hit_q;
  assign bp_idx = bp_idx_q;
  assign PC     = snap_q.pc;
  assign SP     = snap_q.sp;
  assign AF     = snap_q.af;
  assign BC     = snap_q.bc;
  assign DE     = snap_q.de;
  assign HL     = snap_q.hl;
  assign IX     = snap_q.ix;
  assign IY     = snap_q.iy;

endmodule

// File: tb/tb_z80_trace_debugger.sv
// Scoreboard bench for z80_trace_debugger: random M1 fetches, breakpoints,
// run/step and trace pops against a queue-based reference model.
module tb_z80_trace_debugger;

  localparam int NBP = 4;
  localparam int DEP = 16;
  localparam int CW  = 5;

  logic          clk_sys = 1'b0;
  logic          reset, ce, m1_n;
  logic [211:0]  REG_in;
  logic [63:0]   bp_addr;
  logic [3:0]    bp_en;
  logic          halt_req, run, step, tr_rd;
  logic          cpu_wait, halted, bp_hit;
  logic [2:0]    bp_idx;
  logic [15:0]   PC, SP, AF, BC, DE, HL, IX, IY, tr_data;
  logic [CW-1:0] tr_count;
  logic          tr_empty, tr_full;
  logic          spf_o;
`ifdef Z80_DBG_SP_GUARD_EN
  logic [15:0]   sp_lo, sp_hi;
`endif

  z80_trace_debugger #(.NUM_BP(NBP), .TRACE_DEPTH(DEP)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .m1_n(m1_n),
    .REG_in(REG_in), .bp_addr(bp_addr), .bp_en(bp_en),
    .halt_req(halt_req), .run(run), .step(step),
`ifdef Z80_DBG_SP_GUARD_EN
    .sp_lo(sp_lo), .sp_hi(sp_hi), .sp_fault(spf_o),
`endif
    .cpu_wait(cpu_wait), .halted(halted), .bp_hit(bp_hit), .bp_idx(bp_idx),
    .PC(PC), .SP(SP), .AF(AF), .BC(BC), .DE(DE), .HL(HL), .IX(IX), .IY(IY),
    .tr_rd(tr_rd), .tr_data(tr_data), .tr_count(tr_count),
    .tr_empty(tr_empty), .tr_full(tr_full)
  );
`ifndef Z80_DBG_SP_GUARD_EN
  assign spf_o = 1'b0;
`endif

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [127:0] snap;
    bit           wt;
    bit           hit;
    logic [2:0]   idx;
    bit           spf;
    int           cnt;
  } cap_rec_t;

  typedef struct {
    logic [15:0] data;
    int          cnt;
  } pop_rec_t;

  typedef struct {
    bit wt;
    bit spf;
  } ctl_rec_t;

  cap_rec_t exp_cap[$];
  pop_rec_t exp_pop[$];
  ctl_rec_t exp_ctl[$];

  // Reference model: PC history list plus debugger mode
  logic [15:0] hist[$];
  logic [15:0] last_tr;
  int          mode;  // 0 free-running, 1 halted, 2 single step armed
  bit          m_hit;
  logic [2:0]  m_idx;
  bit          m_spf;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  bit cap_ev, pop_ev, ctl_ev, prev_m1;

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cap_ev  <= 1'b0;
      pop_ev  <= 1'b0;
      ctl_ev  <= 1'b0;
      prev_m1 <= 1'b1;
    end else begin
      cap_ev <= ce && !m1_n && prev_m1;
      pop_ev <= tr_rd;
      ctl_ev <= run || step;
      if (ce) prev_m1 <= m1_n;
    end
  end

  always @(negedge clk_sys) begin
    cap_rec_t c;
    pop_rec_t p;
    ctl_rec_t k;
    if (!reset) begin
      if (cap_ev) begin
        if (exp_cap.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL cap_unexpected @%0t", $time);
        end else begin
          c = exp_cap.pop_front();
          chk("snap", {PC, SP, AF, BC, DE, HL, IX, IY}, c.snap);
          chk("cap_wait", cpu_wait, c.wt);
          chk("cap_halted", halted, c.wt);
          chk("cap_bp_hit", bp_hit, c.hit);
          chk("cap_bp_idx", bp_idx, c.idx);
          chk("cap_spf", spf_o, c.spf);
          chk("cap_count", tr_count, c.cnt);
          chk("cap_flags", {tr_empty, tr_full}, {c.cnt == 0, c.cnt == DEP});
        end
      end
      if (pop_ev) begin
        if (exp_pop.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL pop_unexpected @%0t", $time);
        end else begin
          p = exp_pop.pop_front();
          chk("tr_data", tr_data, p.data);
          chk("pop_count", tr_count, p.cnt);
        end
      end
      if (ctl_ev) begin
        if (exp_ctl.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL ctl_unexpected @%0t", $time);
        end else begin
          k = exp_ctl.pop_front();
          chk("ctl_wait", cpu_wait, k.wt);
          chk("ctl_spf", spf_o, k.spf);
        end
      end
    end
  end

  task automatic model_reset();
    hist.delete();
    exp_cap.delete();
    exp_pop.delete();
    exp_ctl.delete();
    last_tr = '0;
    mode    = 0;
    m_hit   = 1'b0;
    m_idx   = '0;
    m_spf   = 1'b0;
  endtask

  task automatic finish_m1();
    int n = 0;
    for (int g = 0; g < 60 && n < 2; g++) begin
      ce = ($urandom_range(0, 3) != 0);
      @(negedge clk_sys);
      if (ce && !cpu_wait) n++;
    end
    if (n < 2) begin
      n_cmp++; n_err++;
      $display("FAIL m1_timeout wait=%0b expected=0", cpu_wait);
    end
    m1_n = 1'b1;
    ce   = 1'b1;
    @(negedge clk_sys);
    ce = 1'($urandom_range(0, 1));
    @(negedge clk_sys);
  endtask

  task automatic fetch(input logic [15:0] pc, input logic [15:0] sp,
                       input bit rd, input bit pre);
    logic [223:0] t;
    logic [211:0] rv;
    cap_rec_t     c;
    pop_rec_t     p;
    bit           h, sf, hlt;
    logic [2:0]   ix;
    for (int k = 0; k < 7; k++) t[32*k +: 32] = $urandom;
    rv = t[211:0];
    rv[64 +: 16] = pc;
    rv[48 +: 16] = sp;
    if (pre) begin
      REG_in = rv; m1_n = 1'b0; ce = 1'b0;
      @(negedge clk_sys);
    end
    h = 1'b0; ix = '0;
    for (int i = 0; i < NBP; i++)
      if (!h && bp_en[i] && bp_addr[16*i +: 16] == pc) begin
        h = 1'b1; ix = 3'(i);
      end
`ifdef Z80_DBG_SP_GUARD_EN
    sf = (sp < sp_lo) || (sp > sp_hi);
`else
    sf = 1'b0;
`endif
    hlt = (mode == 0 && (h || halt_req || sf)) || mode == 2;
    if (rd) begin
      p.data  = (hist.size() != 0) ? hist.pop_front() : last_tr;
      last_tr = p.data;
    end
    if (hist.size() == DEP) void'(hist.pop_front());
    hist.push_back(pc);
    if (rd) begin
      p.cnt = hist.size();
      exp_pop.push_back(p);
    end
    if (hlt) begin
      mode = 1; m_hit = h; m_spf = sf;
      if (h) m_idx = ix;
    end
    c.snap = {pc, sp, rv[15:0], rv[95:80], rv[111:96], rv[127:112],
              rv[143:128], rv[207:192]};
    c.wt = hlt; c.hit = m_hit; c.idx = m_idx; c.spf = m_spf;
    c.cnt = hist.size();
    exp_cap.push_back(c);
    REG_in = rv; m1_n = 1'b0; ce = 1'b1; tr_rd = rd;
    @(negedge clk_sys);
    tr_rd = 1'b0;
    if (!hlt) finish_m1();
  endtask

  task automatic resume(input bit r, input bit s);
    ctl_rec_t k;
    if (mode == 1 && r) begin
      mode = 0; m_spf = 1'b0;
    end else if (mode == 1 && s) begin
      mode = 2; m_spf = 1'b0;
    end
    k.wt = (mode == 1); k.spf = m_spf;
    exp_ctl.push_back(k);
    run = r; step = s; ce = 1'($urandom_range(0, 1));
    @(negedge clk_sys);
    run = 1'b0; step = 1'b0;
  endtask

  task automatic pop1();
    pop_rec_t p;
    p.data  = (hist.size() != 0) ? hist.pop_front() : last_tr;
    last_tr = p.data;
    p.cnt   = hist.size();
    exp_pop.push_back(p);
    tr_rd = 1'b1; ce = 1'($urandom_range(0, 1));
    @(negedge clk_sys);
    tr_rd = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, s;
    logic [15:0] pc;
    reset = 1'b1; ce = 1'b0; m1_n = 1'b1; REG_in = '0;
    bp_addr = '0; bp_en = '0; halt_req = 1'b0;
    run = 1'b0; step = 1'b0; tr_rd = 1'b0;
`ifdef Z80_DBG_SP_GUARD_EN
    sp_lo = 16'h0000; sp_hi = 16'hFFFF;
`endif
    model_reset();
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);

    chk("rst_wait", {cpu_wait, halted, bp_hit}, 3'b000);
    chk("rst_idx", bp_idx, 3'd0);
    chk("rst_snap", {PC, SP, AF, BC, DE, HL, IX, IY}, 128'd0);
    chk("rst_tr_data", tr_data, 16'h0000);
    chk("rst_count", tr_count, 0);
    chk("rst_flags", {tr_empty, tr_full}, 2'b10);
    chk("rst_spf", spf_o, 1'b0);

    // 20 fetches into a 16-deep history; oldest surviving is 0x0004
    for (int i = 0; i < 20; i++) fetch(16'(i), 16'hFF00, 1'b0, (i % 3) == 0);
    for (int i = 0; i < 17; i++) pop1();

    for (int i = 0; i < 16; i++) fetch(16'h0080 + 16'(i), 16'hFE00, 1'b0, 1'b0);
    bp_addr[31:16] = 16'h0100;
    bp_en = 4'b0010;
    fetch(16'h0100, 16'hFE00, 1'b0, 1'b0);
    resume(1'b0, 1'b1);
    finish_m1();
    fetch(16'h0101, 16'hFE00, 1'b0, 1'b0);
    resume(1'b1, 1'b1);
    finish_m1();
    fetch(16'h0102, 16'hFE00, 1'b0, 1'b0);
    resume(1'b1, 1'b0);
    fetch(16'h0103, 16'hFE00, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) pop1();

    for (int it = 0; it < 250; it++) begin
      op = $urandom_range(0, 9);
      case (op)
        0: pop1();
        1: begin
          for (int k = 0; k < 4; k++) bp_addr[16*k +: 16] = 16'($urandom);
          bp_en = 4'($urandom);
        end
        2: halt_req = ($urandom_range(0, 3) == 0);
        3: resume(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: begin
          pc = 16'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            s = $urandom_range(0, 3);
            pc = bp_addr[16*s +: 16];
          end
          fetch(pc, 16'($urandom), $urandom_range(0, 3) == 0,
                1'($urandom_range(0, 1)));
          if (mode == 1) begin
            s = $urandom_range(0, 2);
            resume(s != 1, s != 0);
            finish_m1();
          end
        end
      endcase
    end
    halt_req = 1'b0;
    if (mode == 2) begin
      fetch(16'h0200, 16'hFE00, 1'b0, 1'b0);
      resume(1'b1, 1'b0);
      finish_m1();
    end

    // Halt, then pull reset between clock edges
`ifdef Z80_DBG_SP_GUARD_EN
    bp_en = 4'b0000;
    sp_lo = 16'hF000;
    sp_hi = 16'hFFFF;
    fetch(16'h1234, 16'hEFFE, 1'b0, 1'b0);
    chk("guard_spf", spf_o, 1'b1);
`else
    bp_en = 4'b0001;
    bp_addr[15:0] = 16'h2222;
    fetch(16'h2222, 16'hFE00, 1'b0, 1'b0);
`endif
    chk("pre_rst_halted", halted, 1'b1);
    #2 reset = 1'b1;
    #1 chk("async_rst_wait", {cpu_wait, halted}, 2'b00);
    chk("async_rst_fifo", {tr_empty, tr_full, 3'(tr_count)}, 5'b10000);
    @(negedge clk_sys);
    m1_n = 1'b1;
    ce = 1'b0;
    model_reset();
`ifdef Z80_DBG_SP_GUARD_EN
    sp_lo = 16'h0000;
`endif
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);

    fetch(16'h0042, 16'hFE00, 1'b0, 1'b0);
    pop1();
    repeat (3) @(negedge clk_sys);
    chk("queues_drained", exp_cap.size() + exp_pop.size() + exp_ctl.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
